// File: rtl/latched_encoder8x3_pkg.sv
// Shared constants, state encoding and helpers for the latched 8-to-3 request encoder.
package latched_encoder8x3_pkg;

  localparam int REQ_W = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // One-hot mask selecting the request line named by idx; used to retire a grant.
  function automatic logic [REQ_W-1:0] onehot_of(input logic [IDX_W-1:0] idx);
    logic [REQ_W-1:0] one;
    one = {{(REQ_W-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/latched_encoder8x3_priority_enc8x3.sv
// Combinational 8-to-3 priority encoder with an any-bit flag.
// HI_FIRST=1 picks the highest set bit, HI_FIRST=0 the lowest.
module priority_enc8x3
  import latched_encoder8x3_pkg::*;
#(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic [REQ_W-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_idx;

  // Scan so that the preferred bit is visited last and therefore wins.
  always_comb begin
    w_idx = {IDX_W{1'b0}};
    if (HI_FIRST) begin
      for (int i = 0; i < REQ_W; i++) begin
        w_idx = i_vec[i] ? IDX_W'(i) : w_idx;
      end
    end else begin
      for (int i = REQ_W - 1; i >= 0; i--) begin
        w_idx = i_vec[i] ? IDX_W'(i) : w_idx;
      end
    end
  end

  assign o_idx = w_idx;
  assign o_any = |i_vec;

endmodule

// File: rtl/latched_encoder8x3.sv
// Latched request encoder: sticky pending register, one grant held under a
// valid/ack handshake, granted bit retired on ack.
module latched_encoder8x3
  import latched_encoder8x3_pkg::*;
#(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_W-1:0] D,
  input  logic             E,
  input  logic             ack,
  output logic [IDX_W-1:0] A,
  output logic             V,
  output logic             P
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [REQ_W-1:0] r_pending;
  logic [REQ_W-1:0] w_pending_nxt;
  logic [REQ_W-1:0] w_clr;
  logic [IDX_W-1:0] r_a;
  logic [IDX_W-1:0] w_a_nxt;
  logic             r_v;
  logic             w_v_nxt;
  logic [IDX_W-1:0] w_enc_idx;
  logic             w_enc_any;

  priority_enc8x3 #(.HI_FIRST(HI_FIRST)) u_penc (
    .i_vec (r_pending),
    .o_idx (w_enc_idx),
    .o_any (w_enc_any)
  );

  // Clear mask and pending update; a new capture beats a same-cycle clear.
  always_comb begin
    w_clr = {REQ_W{1'b0}};
    if ((r_state == ST_HOLD) && ack) begin
      w_clr = onehot_of(r_a);
    end else begin
      w_clr = {REQ_W{1'b0}};
    end
    w_pending_nxt = (r_pending & ~w_clr) | (D & {REQ_W{E}});
  end

  // Next-state and registered-output logic of the grant handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_v_nxt     = r_v;
    case (r_state)
      ST_IDLE: begin
        if (w_enc_any) begin
          w_a_nxt     = w_enc_idx;
          w_v_nxt     = 1'b1;
          w_state_nxt = ST_HOLD;
        end else begin
          w_v_nxt     = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (ack) begin
          w_v_nxt     = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_v_nxt     = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_v_nxt     = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pending and output registers; reset drops every request and grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= {REQ_W{1'b0}};
      r_a       <= {IDX_W{1'b0}};
      r_v       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_a       <= w_a_nxt;
      r_v       <= w_v_nxt;
    end
  end

  assign A = r_a;
  assign V = r_v;
  assign P = |r_pending;

endmodule

// File: tb/tb_latched_encoder8x3.sv
// Directed self-checking bench for latched_encoder8x3 (both priority orders).
module tb_latched_encoder8x3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] D;
  logic       E;
  logic       ack;
  logic [2:0] A, A_lo;
  logic       V, V_lo;
  logic       P, P_lo;

  int n_tests = 0;
  int n_fail  = 0;

  latched_encoder8x3 #(.HI_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .D(D), .E(E), .ack(ack), .A(A), .V(V), .P(P)
  );

  latched_encoder8x3 #(.HI_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .D(D), .E(E), .ack(ack), .A(A_lo), .V(V_lo), .P(P_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; D = 8'h00; E = 1'b0; ack = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_A", 8'(A), 8'h00);
    chk("rst_V", 8'(V), 8'h00);
    chk("rst_P", 8'(P), 8'h00);

    // Single request 0x20
    D = 8'h20; E = 1'b1; step(); D = 8'h00;
    chk("single_P1", 8'(P), 8'h01);
    chk("single_V0", 8'(V), 8'h00);
    step();
    chk("single_V", 8'(V), 8'h01);
    chk("single_A", 8'(A), 8'h05);
    step();
    chk("single_hold_V", 8'(V), 8'h01);
    chk("single_hold_A", 8'(A), 8'h05);
    ack = 1'b1; step(); ack = 1'b0;
    chk("single_ack_V", 8'(V), 8'h00);
    chk("single_ack_P", 8'(P), 8'h00);

    // Priority order 0x81 with ack held high
    D = 8'h81; step(); D = 8'h00; ack = 1'b1;
    chk("prio_P", 8'(P), 8'h01);
    chk("prio_V0", 8'(V), 8'h00);
    step();
    chk("prio_V1", 8'(V), 8'h01);
    chk("prio_A1_hi", 8'(A), 8'h07);
    chk("prio_A1_lo", 8'(A_lo), 8'h00);
    step();
    chk("prio_bubble_V", 8'(V), 8'h00);
    chk("prio_bubble_P", 8'(P), 8'h01);
    step();
    chk("prio_V2", 8'(V), 8'h01);
    chk("prio_A2_hi", 8'(A), 8'h00);
    chk("prio_A2_lo", 8'(A_lo), 8'h07);
    step(); ack = 1'b0;
    chk("prio_end_V", 8'(V), 8'h00);
    chk("prio_end_P", 8'(P), 8'h00);
    chk("prio_end_P_lo", 8'(P_lo), 8'h00);

    // Stability under a late higher-priority request
    D = 8'h01; step(); D = 8'h00; step();
    chk("late_V", 8'(V), 8'h01);
    chk("late_A", 8'(A), 8'h00);
    D = 8'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("late_hold_A", 8'(A), 8'h00);
      chk("late_hold_V", 8'(V), 8'h01);
    end
    D = 8'h00; ack = 1'b1; step(); ack = 1'b0;
    chk("late_bubble_V", 8'(V), 8'h00);
    chk("late_bubble_P", 8'(P), 8'h01);
    step();
    chk("late_next_V", 8'(V), 8'h01);
    chk("late_next_A", 8'(A), 8'h07);
    ack = 1'b1; step(); ack = 1'b0;
    chk("late_end_P", 8'(P), 8'h00);

    // Set/clear collision: 0x04 held with ack held
    D = 8'h04; ack = 1'b1; step();
    chk("coll_P0", 8'(P), 8'h01);
    chk("coll_V0", 8'(V), 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("coll_V1", 8'(V), 8'h01);
      chk("coll_A", 8'(A), 8'h02);
      chk("coll_P1", 8'(P), 8'h01);
      step();
      chk("coll_Vb", 8'(V), 8'h00);
      chk("coll_Pb", 8'(P), 8'h01);
    end
    D = 8'h00; step();
    chk("coll_last_V", 8'(V), 8'h01);
    chk("coll_last_A", 8'(A), 8'h02);
    step(); ack = 1'b0;
    chk("coll_end_V", 8'(V), 8'h00);
    chk("coll_end_P", 8'(P), 8'h00);

    // Enable gating
    E = 1'b0; D = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gate_P", 8'(P), 8'h00);
      chk("gate_V", 8'(V), 8'h00);
    end
    E = 1'b1; D = 8'h0A; step(); E = 1'b0; D = 8'hFF;
    chk("gate_cap_P", 8'(P), 8'h01);
    step();
    chk("gate_g1_V", 8'(V), 8'h01);
    chk("gate_g1_A", 8'(A), 8'h03);
    ack = 1'b1; step();
    chk("gate_bub_V", 8'(V), 8'h00);
    chk("gate_bub_P", 8'(P), 8'h01);
    step();
    chk("gate_g2_V", 8'(V), 8'h01);
    chk("gate_g2_A", 8'(A), 8'h01);
    step(); ack = 1'b0;
    chk("gate_end_V", 8'(V), 8'h00);
    chk("gate_end_P", 8'(P), 8'h00);

    // Asynchronous reset mid-HOLD with all requests active
    D = 8'h10; E = 1'b1; step(); D = 8'h00; step();
    chk("arst_pre_V", 8'(V), 8'h01);
    chk("arst_pre_A", 8'(A), 8'h04);
    D = 8'hFF; E = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_A", 8'(A), 8'h00);
    chk("arst_V", 8'(V), 8'h00);
    chk("arst_P", 8'(P), 8'h00);
    step(); step();
    chk("arst_hold_V", 8'(V), 8'h00);
    chk("arst_hold_P", 8'(P), 8'h00);
    chk("arst_hold_A", 8'(A), 8'h00);
    D = 8'h00; E = 1'b0; rst = 1'b0;
    step();
    chk("arst_rel_P", 8'(P), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
